// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: shared board constants and debounce sizing helpers.
package btn_debounce_pkg;
    localparam int CLK_HZ = 12_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 120_000;
    localparam int N_BTN_DEFAULT = 2;

    function automatic int cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction
endpackage

// File: rtl/btn_debounce_if.sv
// btn_debounce_if: raw button pins in, debounced level and edge pulses out.
interface btn_debounce_if
    import btn_debounce_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEFAULT
);
    logic [N_BTN-1:0] BTN_RAW;
    logic [N_BTN-1:0] BTN_LEVEL;
    logic [N_BTN-1:0] BTN_PRESS;
    logic [N_BTN-1:0] BTN_RELEASE;

    modport master (output BTN_RAW, input BTN_LEVEL, input BTN_PRESS, input BTN_RELEASE);
    modport slave  (input BTN_RAW, output BTN_LEVEL, output BTN_PRESS, output BTN_RELEASE);
endinterface

// File: rtl/debounce_chan.sv
// debounce_chan: one button -- two-flop synchronizer, stability counter, level and edge pulses.
module debounce_chan
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rls
);
    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Power-up values match reset so the block works with RST tied low.
    logic          sync1 = 1'b0;
    logic          sync2 = 1'b0;
    logic [CW-1:0] cnt   = '0;
    logic          lvl_q = 1'b0;
    logic          prs_q = 1'b0;
    logic          rls_q = 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            lvl_q <= 1'b0;
            prs_q <= 1'b0;
            rls_q <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prs_q <= 1'b0;
            rls_q <= 1'b0;
            if (sync2 == lvl_q) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                lvl_q <= sync2;
                prs_q <= sync2;
                rls_q <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = lvl_q;
    assign press = prs_q;
    assign rls   = rls_q;
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: N_BTN independent debounce channels behind one interface port.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input logic            CLK,
    input logic            RST,
    btn_debounce_if.slave  bus
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
            .CLK   (CLK),
            .RST   (RST),
            .raw   (bus.BTN_RAW[i]),
            .level (bus.BTN_LEVEL[i]),
            .press (bus.BTN_PRESS[i]),
            .rls   (bus.BTN_RELEASE[i])
        );
    end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed checks of latency, bounce/glitch rejection, simultaneity and reset.
module tb_btn_debounce;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int errors = 0;
    int checks = 0;
    logic pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 CLK = ~CLK;

    btn_debounce_if #(.N_BTN(2)) bus ();

    btn_debounce #(.N_BTN(2), .DEBOUNCE_CYCLES(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic outs(input string tag, input logic [1:0] lv, input logic [1:0] pr, input logic [1:0] rl);
        check({tag, ".level"}, bus.BTN_LEVEL, lv);
        check({tag, ".press"}, bus.BTN_PRESS, pr);
        check({tag, ".release"}, bus.BTN_RELEASE, rl);
    endtask

    task automatic quiet(input string tag, input int n, input logic [1:0] lv);
        for (int e = 1; e <= n; e++) begin
            tick();
            outs($sformatf("%s.e%0d", tag, e), lv, 2'b00, 2'b00);
        end
    endtask

    initial begin
        bus.BTN_RAW = 2'b11;
        tick();
        outs("rst.e1", 2'b00, 2'b00, 2'b00);
        tick();
        tick();
        outs("rst.e3", 2'b00, 2'b00, 2'b00);
        RST = 1'b0;
        quiet("post_rst", 5, 2'b00);
        tick();
        outs("post_rst.e6", 2'b11, 2'b11, 2'b00);
        tick();
        outs("post_rst.e7", 2'b11, 2'b00, 2'b00);

        bus.BTN_RAW = 2'b00;
        quiet("rel_both", 5, 2'b11);
        tick();
        outs("rel_both.e6", 2'b00, 2'b00, 2'b11);
        tick();
        outs("rel_both.e7", 2'b00, 2'b00, 2'b00);

        bus.BTN_RAW = 2'b01;
        quiet("press0", 5, 2'b00);
        tick();
        outs("press0.e6", 2'b01, 2'b01, 2'b00);
        tick();
        outs("press0.e7", 2'b01, 2'b00, 2'b00);

        bus.BTN_RAW = 2'b00;
        quiet("rel0", 5, 2'b01);
        tick();
        outs("rel0.e6", 2'b00, 2'b00, 2'b01);

        // Bounce at the fourth sample: count would otherwise complete on edge 6.
        for (int k = 0; k < 8; k++) begin
            bus.BTN_RAW[0] = pat[k];
            tick();
            outs($sformatf("bounce.e%0d", k + 1), 2'b00, 2'b00, 2'b00);
        end
        tick();
        outs("bounce.e9", 2'b00, 2'b00, 2'b00);
        tick();
        outs("bounce.e10", 2'b01, 2'b01, 2'b00);
        tick();
        outs("bounce.e11", 2'b01, 2'b00, 2'b00);

        for (int e = 1; e <= 12; e++) begin
            bus.BTN_RAW = (e <= 3) ? 2'b11 : 2'b01;
            tick();
            outs($sformatf("glitch1.e%0d", e), 2'b01, 2'b00, 2'b00);
        end

        bus.BTN_RAW = 2'b00;
        quiet("rel0b", 5, 2'b01);
        tick();
        outs("rel0b.e6", 2'b00, 2'b00, 2'b01);
        tick();

        bus.BTN_RAW = 2'b01;
        quiet("midrst", 2, 2'b00);
        RST = 1'b1;
        tick();
        outs("midrst.e3", 2'b00, 2'b00, 2'b00);
        RST = 1'b0;
        quiet("after_rst", 5, 2'b00);
        tick();
        outs("after_rst.e6", 2'b01, 2'b01, 2'b00);
        tick();
        outs("after_rst.e7", 2'b01, 2'b00, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
